// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Brief    : Display-value update handshake between application and scanner.
// Revision : 1.0
// ============================================================================
interface seg7_scan_ctrl_if;
  logic [15:0] in_value;
  logic [3:0]  in_dp;
  logic        in_lzs;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_value, in_dp, in_lzs, in_valid, input  in_ready);
  modport slave  (input  in_value, in_dp, in_lzs, in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : 4-digit common-anode 7-segment scanner with tear-free updates.
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
  parameter int DWELL = 4000,
  parameter int BLANK = 64,
  parameter bit HEX   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  seg7_scan_ctrl_if.slave   bus,
  output logic [7:0]        seg_n,
  output logic [3:0]        dig,
  output logic              frame_tick
);

  localparam int c_CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int c_CW   = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;
  localparam logic [c_CW-1:0] c_DWELL_LAST = c_CW'(DWELL - 1);
  localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t          r_state, w_state_nx;
  logic [1:0]      r_idx, w_idx_nx;
  logic [c_CW-1:0] r_cnt, w_cnt_nx;
  logic            w_boundary;

  logic [15:0] r_act_value, r_pnd_value;
  logic [3:0]  r_act_dp, r_pnd_dp;
  logic        r_act_lzs, r_pnd_lzs;
  logic        r_pend;
  logic        w_xfer;

  logic [3:0]  w_nib;
  logic [3:0]  w_nz;
  logic        w_lead_zero;
  logic [6:0]  w_glyph;
  logic [7:0]  w_seg_lit;

  logic [7:0]  r_seg_n;
  logic [3:0]  r_dig;
  logic        r_frame_tick;

  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    if (!HEX && (n > 4'd9)) g = 7'h00;
    return g;
  endfunction

  // ---------------- scan sequencer ----------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt + 1'b1;
    w_boundary = 1'b0;
    case (r_state)
      S_BLANK: begin
        if (r_cnt == c_BLANK_LAST) begin
          w_state_nx = S_SHOW;
          w_cnt_nx   = '0;
        end
      end
      S_SHOW: begin
        if (r_cnt == c_DWELL_LAST) begin
          w_state_nx = S_BLANK;
          w_idx_nx   = r_idx + 2'd1;
          w_cnt_nx   = '0;
          w_boundary = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_nx = S_BLANK;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // ---------------- shadow / active value registers ----------------
  assign w_xfer       = bus.in_valid & ~r_pend;
  assign bus.in_ready = ~r_pend;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_act_value <= '0;
      r_act_dp    <= '0;
      r_act_lzs   <= 1'b0;
      r_pnd_value <= '0;
      r_pnd_dp    <= '0;
      r_pnd_lzs   <= 1'b0;
      r_pend      <= 1'b0;
    end else if (w_boundary && r_pend) begin
      r_act_value <= r_pnd_value;
      r_act_dp    <= r_pnd_dp;
      r_act_lzs   <= r_pnd_lzs;
      r_pend      <= 1'b0;
    end else if (w_xfer && w_boundary) begin
      // Nothing queued and we are on the seam: skip the shadow stage entirely.
      r_act_value <= bus.in_value;
      r_act_dp    <= bus.in_dp;
      r_act_lzs   <= bus.in_lzs;
    end else if (w_xfer) begin
      r_pnd_value <= bus.in_value;
      r_pnd_dp    <= bus.in_dp;
      r_pnd_lzs   <= bus.in_lzs;
      r_pend      <= 1'b1;
    end
  end

  // ---------------- glyph decode ----------------
  assign w_nib = r_act_value[{r_idx, 2'b00} +: 4];
  assign w_nz  = {|r_act_value[15:12], |r_act_value[11:8],
                  |r_act_value[7:4],   |r_act_value[3:0]};

  always_comb begin
    w_lead_zero = 1'b0;
    case (r_idx)
      2'd1:    w_lead_zero = ~|w_nz[3:1];
      2'd2:    w_lead_zero = ~|w_nz[3:2];
      2'd3:    w_lead_zero = ~w_nz[3];
      default: w_lead_zero = 1'b0;
    endcase
  end

  assign w_glyph   = (r_act_lzs && w_lead_zero) ? 7'h00 : f_glyph(w_nib);
  assign w_seg_lit = {~r_act_dp[r_idx], ~w_glyph};

  // Digit enable and segments come from the same registered state, so they switch together.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dig        <= 4'b0000;
      r_seg_n      <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (r_state == S_SHOW) begin
        r_dig   <= 4'b0001 << r_idx;
        r_seg_n <= w_seg_lit;
      end else begin
        r_dig   <= 4'b0000;
        r_seg_n <= 8'hFF;
      end
    end
  end

  assign dig        = r_dig;
  assign seg_n      = r_seg_n;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Scoreboard bench for seg7_scan_ctrl (DWELL=4, BLANK=1).
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int c_DWELL = 4;
  localparam int c_BLANK = 1;
  localparam int c_SLOT  = c_DWELL + c_BLANK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_n, seg_n_h;
  logic [3:0] dig, dig_h;
  logic       ftick, ftick_h;

  seg7_scan_ctrl_if bus ();
  seg7_scan_ctrl_if bus_h ();

  seg7_scan_ctrl #(.DWELL(c_DWELL), .BLANK(c_BLANK), .HEX(1'b1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus),
    .seg_n(seg_n), .dig(dig), .frame_tick(ftick)
  );

  seg7_scan_ctrl #(.DWELL(c_DWELL), .BLANK(c_BLANK), .HEX(1'b0)) u_dut_h (
    .CLK(clk), .RST_N(rst_n), .bus(bus_h),
    .seg_n(seg_n_h), .dig(dig_h), .frame_tick(ftick_h)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];   // {seg d3, seg d2, seg d1, seg d0} per expected frame

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ftick();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ftick && n < 100);
    check("ftick_wait", {31'd0, ftick}, 32'd1);
  endtask

  task automatic wait_dig(input logic [3:0] d, input bit use_h);
    int n = 0;
    while (((use_h ? dig_h : dig) !== d) && n < 100) begin
      tick();
      n++;
    end
    check("dig_wait", use_h ? dig_h : dig, d);
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] d, input logic l);
    int n = 0;
    bus.in_value = v;
    bus.in_dp    = d;
    bus.in_lzs   = l;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    sb_q.push_back({s3, s2, s1, s0});
  endtask

  // Monitor: a digit-0 slot start pops the next expected frame; later slots compare against it.
  logic [3:0]  prev_dig = 4'b0;
  logic [31:0] mon_cur  = '0;
  bit          mon_act  = 1'b0;
  int          mon_slot = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act  = 1'b0;
      prev_dig = 4'b0;
    end else begin
      if (dig != 4'b0 && prev_dig == 4'b0) begin
        if (dig == 4'b0001 && sb_q.size() > 0) begin
          mon_cur  = sb_q.pop_front();
          mon_act  = 1'b1;
          mon_slot = 0;
        end else if (mon_act) begin
          mon_slot++;
        end
        if (mon_act) begin
          check("sb_dig", dig, 32'd1 << mon_slot);
          check("sb_seg", seg_n, mon_cur[8*mon_slot +: 8]);
          if (mon_slot >= 3) mon_act = 1'b0;
        end
      end
      prev_dig = dig;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic prev_ready;
    int   n;
    bus.in_valid   = 1'b0;  bus.in_value   = '0; bus.in_dp   = '0; bus.in_lzs   = 1'b0;
    bus_h.in_valid = 1'b0;  bus_h.in_value = '0; bus_h.in_dp = '0; bus_h.in_lzs = 1'b0;

    // Reset held for three edges
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_dig",   dig, 0);
    check("rst_seg",   seg_n, 8'hFF);
    check("rst_ready", bus.in_ready, 1);
    check("rst_ftick", ftick, 0);

    bus_h.in_value = 16'h00CC;
    bus_h.in_dp    = 4'b0010;
    bus_h.in_valid = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_h.in_valid = 1'b0;
      if (k == 1 || k == 6) begin
        check("rel_dig_blank", dig, 0);
      end else begin
        check("rel_dig", dig, 4'b0001);
        check("rel_seg", seg_n, 8'hC0);
      end
    end

    // Scan pattern with 1234 for two frames
    send(16'h1234, 4'b0000, 1'b0);
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    wait_ftick();
    for (int j = 1; j <= 4 * c_SLOT; j++) begin
      tick();
      check("scan_dig", dig, (((j - 1) % c_SLOT) == 0) ? 32'd0 : (32'd1 << ((j - 1) / c_SLOT)));
      check("scan_ftick", ftick, (j == 4 * c_SLOT) ? 32'd1 : 32'd0);
    end

    // HEX=0 build: C blank, C with dp shows only dp
    wait_dig(4'b0001, 1'b1);
    check("hex0_c", seg_n_h, 8'hFF);
    wait_dig(4'b0010, 1'b1);
    check("hex0_c_dp", seg_n_h, 8'h7F);
    wait_dig(4'b0100, 1'b1);
    check("hex0_zero", seg_n_h, 8'hC0);

    // Handshake: pending load, ignored second request, commit at boundary
    wait_ftick();
    repeat (5) tick();
    send(16'hAF00, 4'b0000, 1'b0);
    push_frame(8'hC0, 8'hC0, 8'h8E, 8'h88);
    check("hs_ready_drop", bus.in_ready, 0);
    bus.in_value = 16'h5555;
    bus.in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("hs_ready_held", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    n = 0;
    prev_ready = bus.in_ready;
    do begin
      prev_ready = bus.in_ready;
      tick();
      n++;
    end while (!ftick && n < 100);
    check("hs_ready_before", prev_ready, 0);
    check("hs_ready_after", bus.in_ready, 1);

    // Bypass: request exactly on the boundary cycle with nothing pending
    repeat (4 * c_SLOT - 1) tick();
    bus.in_value = 16'h0007;
    bus.in_dp    = 4'b0000;
    bus.in_lzs   = 1'b0;
    bus.in_valid = 1'b1;
    check("byp_ready_pre", bus.in_ready, 1);
    push_frame(8'hF8, 8'hC0, 8'hC0, 8'hC0);
    tick();
    bus.in_valid = 1'b0;
    check("byp_align", ftick, 1);
    check("byp_ready", bus.in_ready, 1);
    repeat (3) tick();
    check("byp_ready_hold", bus.in_ready, 1);

    // Leading-zero suppression with dp on a suppressed digit
    wait_ftick();
    repeat (5) tick();
    send(16'h0040, 4'b1000, 1'b1);
    push_frame(8'hC0, 8'h99, 8'hFF, 8'h7F);
    wait_ftick();
    wait_ftick();

    // Reset while digit 2 is lit and an update is pending
    repeat (3) tick();
    send(16'h8888, 4'b0000, 1'b0);
    check("mid_pend_set", bus.in_ready, 0);
    wait_dig(4'b0100, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_dig",   dig, 0);
    check("mid_rst_seg",   seg_n, 8'hFF);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_ftick", ftick, 0);
    tick();
    rst_n = 1'b1;
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wait_ftick();
    repeat (2) tick();

    check("sb_drained", sb_q.size(), 0);
    check("sb_idle", {31'd0, mon_act}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
